clk_div_monitor: RTL and testbench
==================================

// Module: clk_div_monitor
// PURPOSE
//  Checks the divided clock produced by the odd/even clock divider stage, which
//  sits directly upstream. Runs in the clk_in domain and samples div_clk.
//  Measures the high time, low time and period of div_clk in clk_in cycles.
//  Compares each period to the expected divisor, checks duty balance and reports
//  lock, error and stall status to the test/debug logic.
// PARAMETERS
//  CNT_W        8   width of the phase counters and of div_n; counters saturate at 2**CNT_W-1
//  LOCK_CYCLES  4   consecutive good periods needed before locked asserts
// PORTS
//  clk_in       in   1        system clock; same clock that drives the divider
//  rst_n        in   1        asynchronous, active-low reset
//  div_clk      in   1        divided clock under test
//  div_n        in   CNT_W    expected division ratio; values 0 and 1 disable checking
//  clr_err      in   1        clears err_sticky
//  meas_valid   out  1        1-cycle pulse: new high_time/low_time/period are valid
//  high_time    out  CNT_W    last measured high-phase length, in clk_in cycles
//  low_time     out  CNT_W    last measured low-phase length, in clk_in cycles
//  period       out  CNT_W+1  high_time + low_time of the last full cycle
//  err          out  1        1-cycle pulse on a bad measurement or a stall
//  err_sticky   out  1        stays set after any err until clr_err
//  stall        out  1        1-cycle pulse when div_clk has had no edge for 2**CNT_W-1 cycles
//  locked       out  1        LOCK_CYCLES consecutive good periods seen, none bad since
// BEHAVIOUR
//  Reset: all outputs and counters go to 0 asynchronously. FSM goes to IDLE. Sync/edge regs go to 0.
//  Sampling: s1 <= div_clk; s2 <= s1; s3 <= s2.
//   rise = s2 & ~s3; fall = ~s2 & s3.
//   div_clk changes on either clk_in edge, so it is always sampled through s1.
//  Counters:
//   hi_cnt increments each cycle s2=1; lo_cnt increments each cycle s2=0.
//   On the edge cycle, the counter of the new level loads 1.
//   Both counters saturate at all-ones and never wrap.
//  FSM states IDLE, HIGH, LOW:
//   IDLE: wait for the first rise, then go to HIGH. No measurement is made.
//    A falling edge seen in IDLE is ignored.
//   HIGH: on fall, high_time <= hi_cnt, then go to LOW.
//   LOW: on rise, low_time <= lo_cnt, period <= high_time + lo_cnt,
//    meas_valid pulses, then go to HIGH.
//   HIGH or LOW with the active counter saturated: stall and err pulse,
//    err_sticky set, locked cleared, good count cleared, then go to IDLE.
//  Latency: meas_valid is high in the cycle after the 3rd clk_in posedge.
//   The 1st posedge is the one that first samples div_clk high.
//   period, high_time and low_time update in that same cycle.
//  Check, done in the meas_valid cycle against the current div_n:
//   good = (period == div_n) && (|high_time - low_time| <= 1).
//   Odd N accepts the split ceil(N/2)/floor(N/2) either way round.
//   good: good count increments, saturating at LOCK_CYCLES.
//    locked sets when the count reaches LOCK_CYCLES.
//   bad: err pulses, err_sticky is set, good count and locked clear.
//  div_n < 2: no err from measurements and locked is held 0.
//   Measurements and stall detection still run.
//   A div_n change simply applies from the next measurement.
//  clr_err clears err_sticky. If a new err occurs in the same cycle, the set wins and err_sticky stays 1.
//  err and stall are never asserted for more than 1 cycle per event.
// TESTING
//  div_n=5, div_clk from divider N=5 -> meas_valid every 5 cycles; period=5; {high,low}={3,2}; locked on 4th meas_valid
//  div_n=4, div_clk 2 high/2 low -> period=4, high_time=2, low_time=2, locked after 4 periods, err never 1
//  div_n=5, locked, then insert one 6-cycle period -> err 1 pulse, err_sticky=1, locked=0; relock after 4 good periods
//  CNT_W=8, div_clk held high 300 cycles -> single stall+err pulse at hi_cnt=255, locked=0, FSM IDLE, then recover
//  rst_n low mid-LOW phase -> all outputs 0 immediately; after release, first meas_valid only after 2nd rise
//  clr_err in the same cycle as a bad period -> err_sticky stays 1; div_n=1 with any div_clk -> err stays 0, locked=0

Source files
------------

// File: rtl/clk_div_monitor_if.sv
// +--------------------------------------------------------------------------+
// | Module : clk_div_monitor_if                                              |
// | Brief  : Divided-clock stimulus and measurement/status bundle            |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface clk_div_monitor_if #(
  parameter int CNT_W = 8
);
  logic             div_clk;
  logic [CNT_W-1:0] div_n;
  logic             clr_err;
  logic             meas_valid;
  logic [CNT_W-1:0] high_time;
  logic [CNT_W-1:0] low_time;
  logic [CNT_W:0]   period;
  logic             err;
  logic             err_sticky;
  logic             stall;
  logic             locked;

  modport master (
    output div_clk, div_n, clr_err,
    input  meas_valid, high_time, low_time, period, err, err_sticky, stall, locked
  );

  modport slave (
    input  div_clk, div_n, clr_err,
    output meas_valid, high_time, low_time, period, err, err_sticky, stall, locked
  );
endinterface

`default_nettype wire

// File: rtl/clk_div_monitor.sv
// +--------------------------------------------------------------------------+
// | Module : clk_div_monitor                                                 |
// | Brief  : Measures div_clk high/low/period in clk_in cycles, checks ratio |
// |          and duty balance, reports lock, error and stall status          |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module clk_div_monitor #(
  parameter int CNT_W       = 8,
  parameter int LOCK_CYCLES = 4
) (
  input  wire logic          clk_in,
  input  wire logic          rst_n,
  clk_div_monitor_if.slave   bus
);

  localparam int              GC_W      = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [GC_W-1:0]  C_LOCK    = GC_W'(LOCK_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_s1, r_s2, r_s3;
  logic [CNT_W-1:0] r_hi_cnt, r_lo_cnt;
  logic [GC_W-1:0]  r_good_cnt;
  logic             r_meas_valid;
  logic [CNT_W-1:0] r_high_time, r_low_time;
  logic [CNT_W:0]   r_period;
  logic             r_err, r_err_sticky, r_stall, r_locked;

  logic             w_rise, w_fall, w_stall, w_check_en, w_good;
  logic [CNT_W:0]   w_period_nxt;
  logic [CNT_W-1:0] w_diff;
  logic [GC_W-1:0]  w_gc_inc;

  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= bus.div_clk;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Phase counters restart at 1 on the edge into their level and stick at all-ones.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_hi_cnt <= '0;
      r_lo_cnt <= '0;
    end else begin
      if (w_rise)
        r_hi_cnt <= CNT_W'(1);
      else if (r_s2 && (r_hi_cnt != C_CNT_MAX))
        r_hi_cnt <= r_hi_cnt + CNT_W'(1);

      if (w_fall)
        r_lo_cnt <= CNT_W'(1);
      else if (!r_s2 && (r_lo_cnt != C_CNT_MAX))
        r_lo_cnt <= r_lo_cnt + CNT_W'(1);
    end
  end

  // The check is evaluated on the values about to be published, so err and
  // locked change in the same cycle as meas_valid.
  assign w_period_nxt = {1'b0, r_high_time} + {1'b0, r_lo_cnt};
  assign w_diff       = (r_high_time > r_lo_cnt) ? (r_high_time - r_lo_cnt)
                                                 : (r_lo_cnt - r_high_time);
  assign w_check_en   = (bus.div_n > CNT_W'(1));
  assign w_good       = (w_period_nxt == {1'b0, bus.div_n}) && (w_diff <= CNT_W'(1));
  assign w_gc_inc     = (r_good_cnt == C_LOCK) ? C_LOCK : (r_good_cnt + GC_W'(1));
  assign w_stall      = ((r_state == ST_HIGH) && (r_hi_cnt == C_CNT_MAX)) ||
                        ((r_state == ST_LOW)  && (r_lo_cnt == C_CNT_MAX));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_good_cnt   <= '0;
      r_meas_valid <= 1'b0;
      r_high_time  <= '0;
      r_low_time   <= '0;
      r_period     <= '0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
      r_stall      <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      r_err        <= 1'b0;
      r_stall      <= 1'b0;

      // A clear coinciding with a visible err pulse loses to the set.
      if (r_err)
        r_err_sticky <= 1'b1;
      else if (bus.clr_err)
        r_err_sticky <= 1'b0;

      if (w_stall) begin
        r_stall    <= 1'b1;
        r_err      <= 1'b1;
        r_locked   <= 1'b0;
        r_good_cnt <= '0;
        r_state    <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_rise)
              r_state <= ST_HIGH;
          end
          ST_HIGH: begin
            if (w_fall) begin
              r_high_time <= r_hi_cnt;
              r_state     <= ST_LOW;
            end
          end
          ST_LOW: begin
            if (w_rise) begin
              r_low_time   <= r_lo_cnt;
              r_period     <= w_period_nxt;
              r_meas_valid <= 1'b1;
              r_state      <= ST_HIGH;
              if (!w_check_en) begin
                r_good_cnt <= '0;
              end else if (w_good) begin
                r_good_cnt <= w_gc_inc;
                r_locked   <= (w_gc_inc == C_LOCK);
              end else begin
                r_err      <= 1'b1;
                r_good_cnt <= '0;
                r_locked   <= 1'b0;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end

      if (!w_check_en)
        r_locked <= 1'b0;
    end
  end

  assign bus.meas_valid = r_meas_valid;
  assign bus.high_time  = r_high_time;
  assign bus.low_time   = r_low_time;
  assign bus.period     = r_period;
  assign bus.err        = r_err;
  assign bus.err_sticky = r_err_sticky;
  assign bus.stall      = r_stall;
  assign bus.locked     = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_monitor.sv
// +--------------------------------------------------------------------------+
// | Module : tb_clk_div_monitor                                              |
// | Brief  : Table-driven, scoreboarded bench for clk_div_monitor            |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_clk_div_monitor;

  localparam int CNT_W = 8;

  typedef struct {
    int   dn;
    int   h;
    int   l;
    int   clr_c;
    logic exp_err;
    logic exp_lock;
  } vec_t;

  typedef struct {
    int   hi;
    int   lo;
    int   per;
    logic err;
    logic lock;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_err  = 0;
  int   stall_cnt = 0;
  int   stall_cyc = 0;
  int   err_extra = 0;
  logic allow_err   = 1'b0;
  logic allow_stall = 1'b0;
  exp_t exp_q[$];
  vec_t vecs[21];

  clk_div_monitor_if #(.CNT_W(CNT_W)) bus ();

  clk_div_monitor #(.CNT_W(CNT_W), .LOCK_CYCLES(4)) u_dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every meas_valid pops the oldest expected measurement.
  always @(negedge clk_in) begin
    if (rst_n) begin
      if (bus.meas_valid) begin
        if (exp_q.size() == 0) begin
          check("meas_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("high_time", int'(bus.high_time), e.hi);
          check("low_time",  int'(bus.low_time),  e.lo);
          check("period",    int'(bus.period),    e.per);
          check("meas_err",  int'(bus.err),       int'(e.err));
          check("meas_lock", int'(bus.locked),    int'(e.lock));
        end
      end else begin
        if (bus.err) err_extra++;
        if (!allow_err) check("err_outside_meas", int'(bus.err), 0);
      end
      if (bus.stall) begin
        stall_cnt++;
        stall_cyc = cyc;
        check("stall_with_err", int'(bus.err), 1);
      end
      if (!allow_stall) check("stall_unexpected", int'(bus.stall), 0);
    end
  end

  task automatic drive_v(input int dn, input int h, input int l, input int clr_c,
                         input logic eerr, input logic elock);
    exp_t e;
    for (int c = 0; c < h + l; c++) begin
      @(negedge clk_in);
      bus.div_clk = (c < h);
      if (c == 3) bus.div_n = CNT_W'(dn);
      bus.clr_err = (c == clr_c);
    end
    e.hi = h; e.lo = l; e.per = h + l; e.err = eerr; e.lock = elock;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic v, input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk_in);
      bus.div_clk = v;
      bus.clr_err = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_meas_valid"}, int'(bus.meas_valid), 0);
    check({tag, "_high_time"},  int'(bus.high_time),  0);
    check({tag, "_low_time"},   int'(bus.low_time),   0);
    check({tag, "_period"},     int'(bus.period),     0);
    check({tag, "_err"},        int'(bus.err),        0);
    check({tag, "_err_sticky"}, int'(bus.err_sticky), 0);
    check({tag, "_stall"},      int'(bus.stall),      0);
    check({tag, "_locked"},     int'(bus.locked),     0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    vecs = '{
      '{5, 3, 2, -1, 1'b0, 1'b0}, '{5, 3, 2, -1, 1'b0, 1'b0},
      '{5, 3, 2, -1, 1'b0, 1'b0}, '{5, 2, 3, -1, 1'b0, 1'b1},
      '{5, 3, 3, -1, 1'b1, 1'b0}, '{5, 3, 2, -1, 1'b0, 1'b0},
      '{5, 3, 2, -1, 1'b0, 1'b0}, '{5, 3, 2, -1, 1'b0, 1'b0},
      '{5, 3, 2, -1, 1'b0, 1'b1}, '{5, 4, 1, -1, 1'b1, 1'b0},
      '{4, 2, 2, -1, 1'b0, 1'b0}, '{4, 2, 2, -1, 1'b0, 1'b0},
      '{4, 2, 2, -1, 1'b0, 1'b0}, '{4, 2, 2, -1, 1'b0, 1'b1},
      '{1, 2, 3, -1, 1'b0, 1'b0}, '{1, 6, 2, -1, 1'b0, 1'b0},
      '{7, 5, 3, -1, 1'b1, 1'b0}, '{7, 3, 4, -1, 1'b0, 1'b0},
      '{7, 4, 3, -1, 1'b0, 1'b0}, '{255, 128, 127, -1, 1'b0, 1'b0},
      '{255, 200, 150, -1, 1'b1, 1'b0}
    };

    bus.div_clk = 1'b0;
    bus.div_n   = CNT_W'(5);
    bus.clr_err = 1'b0;
    repeat (3) @(negedge clk_in);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk_in);

    for (int i = 0; i < 21; i++)
      drive_v(vecs[i].dn, vecs[i].h, vecs[i].l, vecs[i].clr_c,
              vecs[i].exp_err, vecs[i].exp_lock);

    // err_sticky: plain clear, then clear colliding with a bad-period err
    drive_v(5, 3, 2, -1, 1'b0, 1'b0);
    check("sticky_after_err", int'(bus.err_sticky), 1);
    drive_v(5, 3, 2, 3, 1'b0, 1'b0);
    check("sticky_cleared", int'(bus.err_sticky), 0);
    drive_v(5, 3, 3, -1, 1'b1, 1'b0);
    drive_v(5, 3, 2, 3, 1'b0, 1'b0);
    check("sticky_set_wins", int'(bus.err_sticky), 1);
    drive_v(5, 3, 2, -1, 1'b0, 1'b0);
    drive_v(5, 3, 2, -1, 1'b0, 1'b0);
    drive_v(5, 3, 2, -1, 1'b0, 1'b1);
    drive_v(5, 3, 2, -1, 1'b0, 1'b1);

    // div_clk stuck high: one stall at hi_cnt saturation, then recovery
    allow_err = 1'b1; allow_stall = 1'b1;
    stall_cnt = 0; err_extra = 0;
    @(negedge clk_in);
    c0 = cyc;
    bus.div_clk = 1'b1;
    hold(1'b1, 299);
    check("stall_count", stall_cnt, 1);
    check("stall_err_count", err_extra, 1);
    check("stall_time", stall_cyc - c0, 258);
    check("stall_locked", int'(bus.locked), 0);
    check("stall_sticky", int'(bus.err_sticky), 1);
    hold(1'b0, 5);
    allow_err = 1'b0; allow_stall = 1'b0;
    drive_v(5, 3, 2, -1, 1'b0, 1'b0);
    drive_v(5, 3, 2, -1, 1'b0, 1'b0);
    drive_v(5, 3, 2, -1, 1'b0, 1'b0);
    drive_v(5, 3, 2, -1, 1'b0, 1'b1);
    drive_v(5, 3, 2, -1, 1'b0, 1'b1);

    // asynchronous reset in the middle of a low phase
    hold(1'b1, 3);
    hold(1'b0, 4);
    check("pre_rst_locked", int'(bus.locked), 1);
    check("pre_rst_high", int'(bus.high_time), 3);
    @(negedge clk_in);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    check("queue_at_rst", exp_q.size(), 0);
    exp_q.delete();
    hold(1'b0, 2);
    @(negedge clk_in);
    rst_n = 1'b1;
    hold(1'b0, 3);
    drive_v(5, 3, 2, -1, 1'b0, 1'b0);
    drive_v(5, 3, 2, -1, 1'b0, 1'b0);
    hold(1'b1, 3);
    hold(1'b0, 3);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
